// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM period/high-time decoder with Avalon-MM slave
//   clk, reset_n      system clock, asynchronous active-low reset
//   pwm_in[NCH-1:0]   asynchronous PWM inputs
//   MMS_addr/read/write/writedata/readdata
//                     word-addressed Avalon-MM slave, read latency 1
//                     0..7 high/period per channel, 8 status, 9 W1C,
//                     A enable mask, B irq enable mask
//   irqout            level interrupt: new capture on an irq-enabled channel
module pwm_capture #(
   parameter int NCH = 3,
   parameter int CW  = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] pwm_in,
   input  logic [3:0]     MMS_addr,
   input  logic           MMS_read,
   input  logic           MMS_write,
   input  logic [31:0]    MMS_writedata,
   output logic [31:0]    MMS_readdata,
   output logic           irqout
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   localparam logic [CW-1:0] CMAX    = '1;
   localparam logic [7:0]    CH_MASK = 8'((9'd1 << NCH) - 9'd1);
   logic [NCH-1:0] r_s1, r_s2, r_prev;
   logic [7:0]     r_en, r_irq_en;
   logic [31:0]    r_rdata;
   logic           r_irq;
   logic [7:0]     w_new, w_tout, w_lvl;
   logic [CW-1:0]  w_high [8];
   logic [CW-1:0]  w_per [8];
   logic [2:0]     w_idx;
   logic           w_wr_clr;
   logic [31:0]    w_rdata;
   logic           w_unused;
   assign w_unused     = ^MMS_writedata;
   assign w_lvl        = 8'(r_s2);
   assign w_idx        = {1'b0, MMS_addr[2:1]};
   assign w_wr_clr     = MMS_write && MMS_addr == 4'h9;
   assign MMS_readdata = r_rdata;
   assign irqout       = r_irq;
   // Channel slots beyond NCH hold zero, so addresses 0..7 of absent channels read 0.
   assign w_rdata = !MMS_addr[3]      ? 32'(MMS_addr[0] ? w_per[w_idx] : w_high[w_idx]) :
                    MMS_addr == 4'h8 ? {8'h0, w_lvl, w_tout, w_new} :
                    MMS_addr == 4'hA ? {24'h0, r_en} :
                    MMS_addr == 4'hB ? {24'h0, r_irq_en} : '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_prev   <= '0;
         r_en     <= '0;
         r_irq_en <= '0;
         r_rdata  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_s1   <= pwm_in;
         r_s2   <= r_s1;
         r_prev <= r_s2;
         if (MMS_write && MMS_addr == 4'hA) r_en <= MMS_writedata[7:0] & CH_MASK;
         if (MMS_write && MMS_addr == 4'hB) r_irq_en <= MMS_writedata[7:0] & CH_MASK;
         if (MMS_read) r_rdata <= w_rdata;
         r_irq <= |(w_new & r_irq_en);
      end
   for (genvar g = 0; g < 8; g++) begin : g_ch
      if (g < NCH) begin : g_on
         state_t        r_state;
         logic [CW-1:0] r_cnt, r_hcur, r_per, r_high;
         logic          r_new, r_tout;
         logic          w_rise, w_fall, w_to, w_cap;
         assign w_rise = r_s2[g] & ~r_prev[g];
         assign w_fall = ~r_s2[g] & r_prev[g];
         // Saturated counter ends the measurement before any edge handling.
         assign w_to   = r_en[g] && r_state != IDLE && r_cnt == CMAX;
         assign w_cap  = r_en[g] && r_state == LOW && w_rise && !w_to;
         assign w_new[g]  = r_new;
         assign w_tout[g] = r_tout;
         assign w_high[g] = r_high;
         assign w_per[g]  = r_per;
         always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_hcur  <= '0;
               r_per   <= '0;
               r_high  <= '0;
               r_new   <= 1'b0;
               r_tout  <= 1'b0;
            end else begin
               // Set has priority over a same-cycle write-1-to-clear.
               r_new  <= w_cap | (r_new & ~(w_wr_clr & MMS_writedata[g]));
               r_tout <= w_to | (r_tout & ~(w_wr_clr & MMS_writedata[8+g]));
               if (!r_en[g] || w_to) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  case (r_state)
                     IDLE: if (w_rise) begin
                        r_state <= HIGH;
                        r_cnt   <= CW'(1);
                     end
                     HIGH: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                           r_hcur  <= r_cnt;
                           r_state <= LOW;
                        end
                     end
                     LOW: if (w_rise) begin
                        r_per   <= r_cnt;
                        r_high  <= r_hcur;
                        r_cnt   <= CW'(1);
                        r_state <= HIGH;
                     end else r_cnt <= r_cnt + 1'b1;
                     default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                     end
                  endcase
               end
            end
      end else begin : g_off
         assign w_new[g]  = 1'b0;
         assign w_tout[g] = 1'b0;
         assign w_high[g] = '0;
         assign w_per[g]  = '0;
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture (register table, directed corners, random waveforms)
module tb_pwm_capture;
   localparam int NCH = 3;
   localparam int CW  = 16;
   localparam int T   = 300;
   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [NCH-1:0] pwm_in = '0;
   logic [3:0]     MMS_addr = '0;
   logic           MMS_read = 1'b0;
   logic           MMS_write = 1'b0;
   logic [31:0]    MMS_writedata = '0;
   logic [31:0]    MMS_readdata;
   logic           irqout;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pwm_capture #(.NCH(NCH), .CW(CW)) dut (
      .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
      .MMS_addr(MMS_addr), .MMS_read(MMS_read), .MMS_write(MMS_write),
      .MMS_writedata(MMS_writedata), .MMS_readdata(MMS_readdata), .irqout(irqout)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v = '{wr, a, d, e};
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
      MMS_addr = a;
      MMS_writedata = d;
      MMS_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      MMS_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      MMS_addr = a;
      MMS_read = 1'b1;
      @(posedge clk);
      @(negedge clk);
      MMS_read = 1'b0;
      d = MMS_readdata;
   endtask

   task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
      MMS_addr = a;
      MMS_writedata = wd;
      MMS_write = 1'b1;
      MMS_read = 1'b1;
      @(posedge clk);
      @(negedge clk);
      MMS_write = 1'b0;
      MMS_read = 1'b0;
      d = MMS_readdata;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      chk(name, d, exp);
   endtask

   task automatic rd_bit(input string name, input int idx, input logic exp);
      logic [31:0] d;
      bus_rd(4'h8, d);
      chk(name, {31'h0, d[idx]}, {31'h0, exp});
   endtask

   task automatic pulse(input int ch, input int h, input int l);
      pwm_in[ch] = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in[ch] = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   initial begin
      logic [31:0]    d;
      logic [NCH-1:0] lv [T+6];
      int             ra, rb, hi, len, ix;
      logic           v, pv;
      // register-map table: reset values, mask widths, W1C/unmapped behaviour
      for (int a = 0; a < 12; a++) add(1'b0, 4'(a), 32'h0, 32'h0);
      add(1'b0, 4'hF, 32'h0, 32'h0);
      add(1'b1, 4'hA, 32'hFF, 32'h0);
      add(1'b0, 4'hA, 32'h0, 32'h7);
      add(1'b1, 4'hB, 32'hFFFF_FFFF, 32'h0);
      add(1'b0, 4'hB, 32'h0, 32'h7);
      add(1'b1, 4'h9, 32'hFFFF, 32'h0);
      add(1'b0, 4'h9, 32'h0, 32'h0);
      add(1'b1, 4'hC, 32'h5, 32'h0);
      add(1'b0, 4'hC, 32'h0, 32'h0);
      add(1'b1, 4'h7, 32'h1234, 32'h0);
      add(1'b0, 4'h7, 32'h0, 32'h0);
      add(1'b0, 4'h8, 32'h0, 32'h0);
      add(1'b1, 4'hA, 32'h0, 32'h0);
      add(1'b0, 4'hA, 32'h0, 32'h0);
      add(1'b1, 4'hB, 32'h0, 32'h0);
      add(1'b0, 4'hB, 32'h0, 32'h0);

      repeat (3) @(negedge clk);
      chk("rst_readdata", MMS_readdata, 32'h0);
      chk("rst_irq", 32'(irqout), 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
         else rd_chk($sformatf("tbl%0d_a%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end

      // interrupt on ch1 capture, others idle
      bus_wr(4'hA, 32'h7);
      bus_wr(4'hB, 32'h2);
      repeat (4) @(negedge clk);
      chk("irq_idle", 32'(irqout), 32'h0);
      pulse(1, 10, 40);
      pwm_in[1] = 1'b1;
      repeat (3) @(negedge clk);
      chk("irq_at_capture", 32'(irqout), 32'h0);
      bus_rd(4'h8, d);
      chk("irq_rise", 32'(irqout), 32'h1);
      chk("irq_status", d, 32'h0002_0002);
      rd_chk("ch1_high", 4'h2, 32'd10);
      rd_chk("ch1_period", 4'h3, 32'd50);
      rd_chk("ch0_high_zero", 4'h0, 32'h0);
      rd_chk("ch0_period_zero", 4'h1, 32'h0);
      rd_chk("ch2_high_zero", 4'h4, 32'h0);
      rd_chk("ch2_period_zero", 4'h5, 32'h0);
      bus_wr(4'h9, 32'h2);
      chk("irq_hold_after_w1c", 32'(irqout), 32'h1);
      @(negedge clk);
      chk("irq_drop", 32'(irqout), 32'h0);
      rd_chk("irq_status_cleared", 4'h8, 32'h0002_0000);
      pwm_in[1] = 1'b0;
      bus_wr(4'hA, 32'h0);
      bus_wr(4'hB, 32'h0);
      bus_wr(4'h9, 32'hFFFF);

      // ch0 30/70 basic measurement and W1C
      bus_wr(4'hA, 32'h1);
      repeat (3) @(negedge clk);
      pulse(0, 30, 70);
      pwm_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      rd_chk("ch0_high_30", 4'h0, 32'd30);
      rd_chk("ch0_period_100", 4'h1, 32'd100);
      rd_bit("ch0_new_set", 0, 1'b1);
      bus_wr(4'h9, 32'h1);
      rd_bit("ch0_new_cleared", 0, 1'b0);
      pwm_in[0] = 1'b0;
      repeat (20) @(negedge clk);
      pwm_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      rd_bit("ch0_new_reset", 0, 1'b1);

      // disable mid-HIGH, re-enable during LOW: no truncated report
      bus_wr(4'h9, 32'hFFFF);
      pwm_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      pwm_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      bus_wr(4'hA, 32'h0);
      pwm_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      bus_wr(4'h9, 32'hFFFF);
      bus_wr(4'hA, 32'h1);
      repeat (5) @(negedge clk);
      rd_bit("reen_no_flag", 0, 1'b0);
      pulse(0, 30, 69);
      rd_bit("reen_first_rise_no_report", 0, 1'b0);
      pwm_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      rd_chk("reen_high_30", 4'h0, 32'd30);
      rd_chk("reen_period_100", 4'h1, 32'd100);
      rd_bit("reen_new_set", 0, 1'b1);

      // W1C on the capture cycle: set wins
      pwm_in[0] = 1'b0;
      repeat (50) @(negedge clk);
      bus_wr(4'h9, 32'hFFFF);
      pwm_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      bus_wr(4'h9, 32'h1);
      rd_bit("set_wins", 0, 1'b1);
      bus_wr(4'h9, 32'h1);
      rd_bit("w1c_after_set", 0, 1'b0);

      // read on the capture cycle returns the old value
      pwm_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      pulse(0, 30, 70);
      pulse(0, 20, 40);
      pwm_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      rd_chk("rd_at_capture_old", 4'h1, 32'd100);
      rd_chk("rd_after_capture_new", 4'h1, 32'd60);
      rd_chk("rd_new_high", 4'h0, 32'd20);
      repeat (3) @(negedge clk);
      chk("readdata_hold", MMS_readdata, 32'd20);
      rd_chk("unmapped_7", 4'h7, 32'h0);

      // read and write in the same cycle
      bus_rw(4'hA, 32'h4, d);
      chk("rw_read_old", d, 32'h1);
      rd_chk("rw_write_took", 4'hA, 32'h4);
      pwm_in[0] = 1'b0;

      // ch2 timeout
      bus_wr(4'h9, 32'hFFFF);
      repeat (3) @(negedge clk);
      pulse(2, 10, 40);
      pulse(2, 10, 40);
      pwm_in[2] = 1'b1;
      repeat (65537) @(negedge clk);
      rd_bit("tout_not_yet", 10, 1'b0);
      rd_bit("tout_set", 10, 1'b1);
      rd_chk("tout_high_held", 4'h4, 32'd10);
      rd_chk("tout_period_held", 4'h5, 32'd50);
      bus_wr(4'h9, 32'hFFFF);
      pwm_in[2] = 1'b0;
      repeat (5) @(negedge clk);
      pwm_in[2] = 1'b1;
      repeat (5) @(negedge clk);
      rd_bit("tout_idle_no_capture", 2, 1'b0);
      rd_bit("tout_cleared", 10, 1'b0);
      pwm_in[2] = 1'b0;

      // random waveforms on all channels against an edge-list model
      for (int r = 0; r < 8; r++) begin
         bus_wr(4'hA, 32'h0);
         bus_wr(4'h9, 32'hFFFF);
         pwm_in = '0;
         repeat (4) @(negedge clk);
         bus_wr(4'hA, 32'h7);
         for (int c = 0; c < NCH; c++) begin
            ix = 0;
            v = 1'b0;
            while (ix < T) begin
               len = int'($urandom_range(1, 40));
               for (int k = 0; k < len && ix < T; k++) begin
                  lv[ix][c] = v;
                  ix++;
               end
               v = ~v;
            end
            for (int k = T; k < T + 6; k++) lv[k][c] = lv[T-1][c];
         end
         for (int i = 0; i < T + 6; i++) begin
            pwm_in = lv[i];
            @(negedge clk);
         end
         for (int c = 0; c < NCH; c++) begin
            ra = -1;
            rb = -1;
            pv = 1'b0;
            for (int i = 0; i < T + 6; i++) begin
               if (lv[i][c] && !pv) begin
                  ra = rb;
                  rb = i;
               end
               pv = lv[i][c];
            end
            hi = 0;
            for (int i = ra; i < rb; i++) hi += int'(lv[i][c]);
            rd_chk($sformatf("rnd%0d_ch%0d_high", r, c), 4'(2*c), 32'(hi));
            rd_chk($sformatf("rnd%0d_ch%0d_period", r, c), 4'(2*c+1), 32'(rb - ra));
         end
         rd_chk($sformatf("rnd%0d_status", r), 4'h8, (32'(lv[T+5]) << 16) | 32'h7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
